umem_arb: RTL and testbench
===========================

# umem_arb

Unified-memory arbiter and stall controller for the 16-bit pipelined core. It shares one single-ported, fixed-latency memory between the instruction-fetch port (IF stage) and the data port (MEM stage). It sequences each access through a small FSM and drives the stall signals that freeze the pipeline flops, including the MEM/WB register write enable. One access is in flight at a time; a completed access is acknowledged with a one-cycle valid pulse.

## Interface
- LAT, 2, memory access latency in cycles; legal range 1..15.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; held until i_valid
- i_addr  in  16  fetch address
- i_rdata  out  16  fetched instruction; meaningful only while i_valid
- i_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_valid
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  16  data address
- d_wdata  in  16  store data
- d_rdata  out  16  load data; meaningful only while d_valid
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- stall_if  out  1  i_req & ~i_valid
- stall_mem  out  1  d_req & ~d_valid; pipeline freezes IF..EX/MEM; MEM/WB write_en = ~stall_mem
- mem_req  out  1  memory access active
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid in last BUSY cycle

## Operation
- States: IDLE, BUSY, DONE. Internal regs: owner (0 = I, 1 = D), last_d (previous grant was data), cnt[3:0], latched addr/wdata/wr, rdata holding register.
- IDLE: if d_req or i_req, grant and go to BUSY with cnt = LAT-1. Otherwise stay.
- Grant rule: D wins, unless both are pending and last_d = 1; then I wins. Owner is written into last_d at grant.
- At grant, latch the winner's addr, wdata, and wr; an I grant forces wr = 0. Requester inputs are ignored until DONE.
- BUSY: mem_req = 1. mem_addr, mem_wdata, and mem_wr are driven from the latches and held stable. cnt decrements each cycle.
  - At cnt = 0, capture mem_rdata into the holding register and go to DONE.
- DONE: pulse the owner's valid. i_rdata/d_rdata are driven from the holding register. The memory is idle. Next state is IDLE.
- Outside BUSY: mem_req = mem_wr = 0 and mem_addr = mem_wdata = 0.
- For a store, d_valid still pulses; d_rdata is don't-care.
- A request that drops before its valid is protocol error; behaviour is undefined, with no assertion required.
- Reset (any time, including mid-BUSY):
  - state = IDLE, last_d = 0, cnt = 0, latches and holding reg = 0.
  - All outputs 0. stall_* follow their inputs combinationally.
  - An aborted access produces no valid pulse.

## Timing
- A request sampled in IDLE at cycle t puts BUSY in cycles t+1..t+LAT, DONE in t+LAT+1, and IDLE in t+LAT+2.
- Request-to-valid latency is LAT+1 cycles. Throughput is one access per LAT+2 cycles.
- stall_if and stall_mem are combinational. They deassert in the DONE cycle, so the stage advances on the edge ending DONE.
- A request still high in IDLE after its DONE is treated as a new request.
- A simultaneous i_req and d_req alternate I/D when both stay asserted. This prevents fetch starvation under back-to-back loads.
- mem_wr is high for all LAT BUSY cycles of a store. The memory commits the write at the end of the last BUSY cycle.

## Test plan
- **Reset mid-access:** LAT=2, d_req load 0x0040 granted, rst low in the first BUSY cycle.
  - All outputs go 0 immediately. No d_valid ever pulses.
  - After release, a re-presented d_req completes normally 3 cycles later.
- **Single fetch:** LAT=2, i_req addr 0x0010 at cycle 0, memory returns 0xA5C3.
  - mem_req is high in cycles 1–2 with mem_addr 0x0010.
  - i_valid pulses in cycle 3 with i_rdata 0xA5C3. stall_if is high in cycles 0–2.
- **Store:** LAT=3, d_wr=1, addr 0x1234, wdata 0xBEEF.
  - mem_wr and mem_req are high in cycles 1–3 with 0x1234/0xBEEF.
  - d_valid pulses in cycle 4. A load of 0x1234 issued afterwards returns 0xBEEF.
- **Contention:** LAT=1, i_req and d_req held continuously.
  - Grant order is D, I, D, I.
  - Valid pulses land at cycles 2 (d), 5 (i), 8 (d), 11 (i).
- **Input change during BUSY:** LAT=2, d_addr changes from 0x0100 to 0x0200 during BUSY.
  - mem_addr stays 0x0100 throughout.
- **LAT=1 back-to-back data:** new d_req in the cycle after DONE.
  - d_valid pulses at cycles 2 and 5.
  - stall_mem is low exactly in cycles 2 and 5 (cycle 3 is the post-DONE IDLE grant, with the new d_req high).

Source files
------------

// File: rtl/umem_arb.sv
// umem_arb -- unified-memory arbiter and stall controller.
//
// Shares one single-ported, fixed-latency memory between the instruction
// fetch port (IF stage) and the data port (MEM stage). Only one access is
// in flight at a time. Each access is sequenced IDLE -> BUSY (LAT cycles)
// -> DONE. DONE pulses the owner's valid for one cycle.
//
// Parameters
//   LAT        memory access latency in cycles, legal range 1..15
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   i_req      fetch request, held until i_valid
//   i_addr     fetch address
//   i_rdata    fetched instruction, meaningful while i_valid
//   i_valid    one-cycle fetch completion pulse
//   d_req      data request, held until d_valid
//   d_wr       1 = store, 0 = load
//   d_addr     data address
//   d_wdata    store data
//   d_rdata    load data, meaningful while d_valid
//   d_valid    one-cycle data completion pulse (loads and stores)
//   stall_if   fetch stall:  i_req & ~i_valid
//   stall_mem  data stall:   d_req & ~d_valid (MEM/WB write_en = ~stall_mem)
//   mem_req    memory access active (BUSY only)
//   mem_wr     memory write strobe (BUSY only)
//   mem_addr   memory address (BUSY only, else 0)
//   mem_wdata  memory write data (BUSY only, else 0)
//   mem_rdata  memory read data, valid in the last BUSY cycle
module umem_arb #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state_q, state_d;
  logic        owner_q;   // 0 = fetch, 1 = data
  logic        last_d_q;  // previous grant went to the data port
  logic        wr_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        grant;
  logic        grant_d;

  // Data normally wins; when both ports are waiting and data had the last
  // grant, fetch goes first so back-to-back loads cannot starve IF.
  assign grant_d = d_req & ~(i_req & last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_req   = 1'b1;
        mem_wr    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        i_valid = ~owner_q;
        d_valid = owner_q;
        i_rdata = owner_q ? 16'h0000 : rdata_q;
        d_rdata = owner_q ? rdata_q : 16'h0000;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stalls release in DONE so the stage advances on the edge ending DONE.
  assign stall_if  = i_req & ~i_valid;
  assign stall_mem = d_req & ~d_valid;

  // Grant latches: requester inputs are not looked at again until the
  // access completes, so mem_* stay stable for the whole BUSY window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= 1'b0;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (grant) begin
      owner_q  <= grant_d;
      last_d_q <= grant_d;
      wr_q     <= grant_d & d_wr;
      cnt_q    <= CNT_INIT;
      addr_q   <= grant_d ? d_addr : i_addr;
      wdata_q  <= grant_d ? d_wdata : 16'h0000;
    end else if (state_q == BUSY) begin
      if (cnt_q == 4'd0) begin
        rdata_q <= mem_rdata;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_umem_arb.sv
// Testbench for umem_arb: three instances with LAT = 1, 2, 3, each with its
// own fixed-latency memory and a cycle-arithmetic reference model.
module tb_umem_arb;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req     [N];
  logic [15:0] i_addr    [N];
  logic [15:0] i_rdata   [N];
  logic        i_valid   [N];
  logic        d_req     [N];
  logic        d_wr      [N];
  logic [15:0] d_addr    [N];
  logic [15:0] d_wdata   [N];
  logic [15:0] d_rdata   [N];
  logic        d_valid   [N];
  logic        stall_if  [N];
  logic        stall_mem [N];
  logic        mem_req   [N];
  logic        mem_wr    [N];
  logic [15:0] mem_addr  [N];
  logic [15:0] mem_wdata [N];
  logic [15:0] mem_rdata [N];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      umem_arb #(.LAT(g + 1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req[g]),
        .i_addr   (i_addr[g]),
        .i_rdata  (i_rdata[g]),
        .i_valid  (i_valid[g]),
        .d_req    (d_req[g]),
        .d_wr     (d_wr[g]),
        .d_addr   (d_addr[g]),
        .d_wdata  (d_wdata[g]),
        .d_rdata  (d_rdata[g]),
        .d_valid  (d_valid[g]),
        .stall_if (stall_if[g]),
        .stall_mem(stall_mem[g]),
        .mem_req  (mem_req[g]),
        .mem_wr   (mem_wr[g]),
        .mem_addr (mem_addr[g]),
        .mem_wdata(mem_wdata[g]),
        .mem_rdata(mem_rdata[g])
      );
    end
  endgenerate

  // Background memory contents (before any store).
  function automatic logic [15:0] base(input int k, input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5C3;
    return a ^ 16'h5A5A ^ 16'(k * 16'h1111);
  endfunction

  // ---------------- bench memory (driven by the DUT) ----------------
  logic [15:0] img  [N][65536];
  bit          imgv [N][65536];
  int          run  [N];

  // Data appears only in the last BUSY cycle; garbage otherwise.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      mem_rdata[k] = 16'hDEAD;
      if (mem_req[k] && run[k] == k)
        mem_rdata[k] = imgv[k][mem_addr[k]] ? img[k][mem_addr[k]] : base(k, mem_addr[k]);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      run[k] <= mem_req[k] ? run[k] + 1 : 0;
      if (mem_req[k] && mem_wr[k] && run[k] == k) begin
        img[k][mem_addr[k]]  <= mem_wdata[k];
        imgv[k][mem_addr[k]] <= 1'b1;
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          have [N];
  int          tg   [N];
  bit          own  [N];
  bit          ld   [N];
  bit          twr  [N];
  logic [15:0] ta   [N];
  logic [15:0] tw   [N];
  logic [15:0] mimg  [N][65536];
  bit          mimgv [N][65536];

  task automatic cmp(input string nm, input int k, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h want=%h", nm, k + 1, cyc, act, exp);
    end
  endtask

  // A grant at cycle tg occupies the memory in tg+1..tg+L, completes at
  // tg+L+1 and the arbiter is free again from tg+L+2.
  task automatic model_check();
    for (int k = 0; k < N; k++) begin
      int L;
      bit busy, done, idle, dw;
      logic e_req, e_wr, e_iv, e_dv;
      logic [15:0] e_addr, e_wd, e_rd;
      L = k + 1;
      e_req = 0; e_wr = 0; e_iv = 0; e_dv = 0;
      e_addr = 0; e_wd = 0; e_rd = 0;
      if (!rst) begin
        have[k] = 0;
        ld[k]   = 0;
      end
      busy = have[k] && (cyc > tg[k]) && (cyc <= tg[k] + L);
      done = have[k] && (cyc == tg[k] + L + 1);
      idle = rst && (!have[k] || (cyc >= tg[k] + L + 2));
      if (busy) begin
        e_req = 1; e_wr = twr[k]; e_addr = ta[k]; e_wd = tw[k];
      end
      if (done) begin
        e_iv = !own[k];
        e_dv = own[k];
        e_rd = mimgv[k][ta[k]] ? mimg[k][ta[k]] : base(k, ta[k]);
        if (twr[k]) begin
          mimg[k][ta[k]]  = tw[k];
          mimgv[k][ta[k]] = 1'b1;
        end
      end
      cmp("m_mem_req", k, mem_req[k], e_req);
      cmp("m_mem_wr", k, mem_wr[k], e_wr);
      cmp("m_mem_addr", k, mem_addr[k], e_addr);
      if (!(busy && !own[k])) cmp("m_mem_wdata", k, mem_wdata[k], e_wd);
      cmp("m_i_valid", k, i_valid[k], e_iv);
      cmp("m_d_valid", k, d_valid[k], e_dv);
      cmp("m_stall_if", k, stall_if[k], i_req[k] & ~e_iv);
      cmp("m_stall_mem", k, stall_mem[k], d_req[k] & ~e_dv);
      if (e_iv) cmp("m_i_rdata", k, i_rdata[k], e_rd);
      if (e_dv && !twr[k]) cmp("m_d_rdata", k, d_rdata[k], e_rd);
      if (idle && (i_req[k] || d_req[k])) begin
        dw      = d_req[k] && !(i_req[k] && ld[k]);
        have[k] = 1;
        tg[k]   = cyc;
        own[k]  = dw;
        ld[k]   = dw;
        ta[k]   = dw ? d_addr[k] : i_addr[k];
        tw[k]   = dw ? d_wdata[k] : 16'h0000;
        twr[k]  = dw && d_wr[k];
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_wr[k] = 0;
      d_addr[k] = 0; d_wdata[k] = 0;
    end
    d_req[0] = 1'b1;
    i_req[2] = 1'b1;
    sample();
    for (int k = 0; k < N; k++) begin
      cmp("rst_mem_req", k, mem_req[k], 1'b0);
      cmp("rst_valid", k, {15'd0, i_valid[k] | d_valid[k]}, 16'h0000);
    end
    cmp("rst_stall_mem_follow", 0, stall_mem[0], 1'b1);
    cmp("rst_stall_if_follow", 2, stall_if[2], 1'b1);
    adv();
    d_req[0] = 1'b0;
    i_req[2] = 1'b0;
    rst = 1'b1;
    sample(); adv();

    // Single fetch, LAT=2.
    i_req[1] = 1'b1; i_addr[1] = 16'h0010;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) i_req[1] = 1'b0;
      sample();
      cmp("fetch_mem_req", 1, mem_req[1], c == 1 || c == 2);
      if (c == 1 || c == 2) cmp("fetch_mem_addr", 1, mem_addr[1], 16'h0010);
      cmp("fetch_i_valid", 1, i_valid[1], c == 3);
      if (c == 3) cmp("fetch_i_rdata", 1, i_rdata[1], 16'hA5C3);
      if (c < 4) cmp("fetch_stall_if", 1, stall_if[1], c < 3);
      adv();
    end

    // Store then load back, LAT=3.
    d_req[2] = 1'b1; d_wr[2] = 1'b1; d_addr[2] = 16'h1234; d_wdata[2] = 16'hBEEF;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) begin d_req[2] = 1'b0; d_wr[2] = 1'b0; end
      sample();
      cmp("st_mem_req", 2, mem_req[2], c >= 1 && c <= 3);
      cmp("st_mem_wr", 2, mem_wr[2], c >= 1 && c <= 3);
      if (c >= 1 && c <= 3) begin
        cmp("st_mem_addr", 2, mem_addr[2], 16'h1234);
        cmp("st_mem_wdata", 2, mem_wdata[2], 16'hBEEF);
      end
      cmp("st_d_valid", 2, d_valid[2], c == 4);
      if (c < 5) cmp("st_stall_mem", 2, stall_mem[2], c < 4);
      adv();
    end
    d_req[2] = 1'b1; d_wr[2] = 1'b0; d_addr[2] = 16'h1234; d_wdata[2] = 16'h0000;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) d_req[2] = 1'b0;
      sample();
      cmp("ld_mem_wr", 2, mem_wr[2], 1'b0);
      cmp("ld_d_valid", 2, d_valid[2], c == 4);
      if (c == 4) cmp("ld_d_rdata", 2, d_rdata[2], 16'hBEEF);
      adv();
    end

    // Contention, LAT=1: D, I, D, I.
    i_req[0] = 1'b1; i_addr[0] = 16'h0300;
    d_req[0] = 1'b1; d_addr[0] = 16'h0400; d_wr[0] = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c == 12) begin i_req[0] = 1'b0; d_req[0] = 1'b0; end
      sample();
      if (c < 12) begin
        cmp("cont_d_valid", 0, d_valid[0], c == 2 || c == 8);
        cmp("cont_i_valid", 0, i_valid[0], c == 5 || c == 11);
      end
      if (c == 1 || c == 7) cmp("cont_addr_d", 0, mem_addr[0], 16'h0400);
      if (c == 4 || c == 10) cmp("cont_addr_i", 0, mem_addr[0], 16'h0300);
      adv();
    end

    // Input change during BUSY, LAT=2.
    d_req[1] = 1'b1; d_wr[1] = 1'b0; d_addr[1] = 16'h0100; d_wdata[1] = 16'h0000;
    for (int c = 0; c <= 4; c++) begin
      if (c == 1) begin d_addr[1] = 16'h0200; d_wdata[1] = 16'h7777; end
      if (c == 4) d_req[1] = 1'b0;
      sample();
      if (c == 1 || c == 2) cmp("chg_mem_addr", 1, mem_addr[1], 16'h0100);
      cmp("chg_d_valid", 1, d_valid[1], c == 3);
      if (c == 3) cmp("chg_d_rdata", 1, d_rdata[1], 16'h4A4B);
      adv();
    end

    // Back-to-back data, LAT=1.
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 16'h0500;
    for (int c = 0; c <= 6; c++) begin
      if (c == 3) d_addr[0] = 16'h0501;
      if (c == 6) d_req[0] = 1'b0;
      sample();
      if (c < 6) begin
        cmp("b2b_d_valid", 0, d_valid[0], c == 2 || c == 5);
        cmp("b2b_stall_mem", 0, stall_mem[0], !(c == 2 || c == 5));
      end
      if (c == 2) cmp("b2b_rdata0", 0, d_rdata[0], 16'h5F5A);
      if (c == 5) cmp("b2b_rdata1", 0, d_rdata[0], 16'h5F5B);
      adv();
    end

    // Reset in the first BUSY cycle, LAT=2.
    d_req[1] = 1'b1; d_wr[1] = 1'b0; d_addr[1] = 16'h0040; d_wdata[1] = 16'h0000;
    for (int c = 0; c <= 8; c++) begin
      if (c == 1) rst = 1'b0;
      if (c == 2) d_req[1] = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) d_req[1] = 1'b1;
      if (c == 8) d_req[1] = 1'b0;
      sample();
      if (c == 1) begin
        cmp("rmid_mem_req", 1, mem_req[1], 1'b0);
        cmp("rmid_mem_addr", 1, mem_addr[1], 16'h0000);
        cmp("rmid_stall_mem", 1, stall_mem[1], 1'b1);
      end
      if (c >= 1 && c <= 7) cmp("rmid_d_valid", 1, d_valid[1], c == 7);
      if (c == 5 || c == 6) cmp("rmid_re_addr", 1, mem_addr[1], 16'h0040);
      if (c == 7) cmp("rmid_d_rdata", 1, d_rdata[1], 16'h4B0B);
      adv();
    end

    for (int c = 0; c < 3; c++) begin
      sample();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
